// File: rtl/gbvga_pkg.sv
// Shared Game Boy LCD / framebuffer geometry for the capture and VGA output stages.
package gbvga_pkg;

    localparam int unsigned GB_H_PIX   = 160;
    localparam int unsigned GB_V_LINES = 144;
    localparam int unsigned FB_ADDR_W  = 15;
    localparam int unsigned FB_DATA_W  = 2;

    // Counters must hold one past the last pixel/line to express overrun.
    localparam int unsigned X_W = 8;
    localparam int unsigned Y_W = 8;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [FB_DATA_W-1:0] data;
    } fb_wr_t;

    function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [X_W-1:0] x,
                                                     input logic [Y_W-1:0] y);
        return FB_ADDR_W'(y) * FB_ADDR_W'(GB_H_PIX) + FB_ADDR_W'(x);
    endfunction

endpackage

// File: rtl/gb_sig_filter.sv
// Two-flop synchronizer plus FILTER_LEN-sample agreement filter with edge pulses.
module gb_sig_filter #(
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    localparam int unsigned HW = FILTER_LEN - 1;

    logic          s1;
    logic          s2;
    logic [HW-1:0] hist;
    logic          all_one;
    logic          all_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            hist  <= '0;
            level <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            hist <= HW'({hist, s2});
            if (rise_c) begin
                level <= 1'b1;
            end else if (fall_c) begin
                level <= 1'b0;
            end
        end
    end

    // Current sample plus the previous FILTER_LEN-1 must all agree.
    always_comb begin
        all_one  = s2 & (&hist);
        all_zero = ~(s2 | (|hist));
        rise_c   = all_one & ~level;
        fall_c   = all_zero & level;
    end

endmodule

// File: rtl/gb_lcd_capture.sv
// Captures the Game Boy LCD pixel stream into framebuffer write strobes (y*160+x).
module gb_lcd_capture
    import gbvga_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 3,
    parameter bit          INVERT_DATA = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [FB_DATA_W-1:0] idata,
    input  logic                 iclk,
    input  logic                 ihsync,
    input  logic                 ivsync,
    output logic                 wr_en,
    output logic [FB_ADDR_W-1:0] wr_addr,
    output logic [FB_DATA_W-1:0] wr_data,
    output logic                 frame_start,
    output logic                 locked,
    output logic                 line_overrun,
    output logic                 frame_overrun
);

    localparam logic [X_W-1:0] X_END = X_W'(GB_H_PIX);
    localparam logic [Y_W-1:0] Y_END = Y_W'(GB_V_LINES);

    logic [FB_DATA_W-1:0] d_s1;
    logic [FB_DATA_W-1:0] d_s2;

    logic clk_level, clk_rise, pix_c;
    logic hs_level, hs_rise, hs_fall;
    logic vs_level, vs_rise, vs_fall;
    logic unused_filt;

    logic [X_W-1:0] x, x_n;
    logic [Y_W-1:0] y, y_n;
    logic           locked_n;
    fb_wr_t         wr_n;
    logic           wr_en_n;
    logic           line_overrun_n;
    logic           frame_overrun_n;

    gb_sig_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk(clk), .rst_n(rst_n), .din(iclk),
        .level(clk_level), .rise_c(clk_rise), .fall_c(pix_c)
    );

    gb_sig_filter #(.FILTER_LEN(FILTER_LEN)) u_hs_filt (
        .clk(clk), .rst_n(rst_n), .din(ihsync),
        .level(hs_level), .rise_c(hs_rise), .fall_c(hs_fall)
    );

    gb_sig_filter #(.FILTER_LEN(FILTER_LEN)) u_vs_filt (
        .clk(clk), .rst_n(rst_n), .din(ivsync),
        .level(vs_level), .rise_c(vs_rise), .fall_c(vs_fall)
    );

    assign unused_filt = ^{clk_level, clk_rise, hs_level, hs_fall, vs_level, vs_fall};

    // Vsync is applied first so a coincident pixel lands at address 0;
    // hsync is applied last so a coincident pixel stays on the current line.
    always_comb begin
        x_n             = x;
        y_n             = y;
        locked_n        = locked;
        wr_en_n         = 1'b0;
        wr_n.addr       = wr_addr;
        wr_n.data       = wr_data;
        line_overrun_n  = line_overrun;
        frame_overrun_n = frame_overrun;

        if (vs_rise) begin
            x_n      = '0;
            y_n      = '0;
            locked_n = 1'b1;
        end

        if (pix_c && locked_n) begin
            if (x_n == X_END) begin
                line_overrun_n = 1'b1;
            end
            if (y_n == Y_END) begin
                frame_overrun_n = 1'b1;
            end
            if ((x_n < X_END) && (y_n < Y_END)) begin
                wr_en_n   = 1'b1;
                wr_n.addr = fb_addr(x_n, y_n);
                wr_n.data = INVERT_DATA ? ~d_s2 : d_s2;
                x_n       = x_n + X_W'(1);
            end
        end

        if (hs_rise && !vs_rise && locked_n) begin
            if ((x_n != '0) && (y_n != Y_END)) begin
                y_n = y_n + Y_W'(1);
            end
            x_n = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_s1          <= '0;
            d_s2          <= '0;
            x             <= '0;
            y             <= '0;
            locked        <= 1'b0;
            wr_en         <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            frame_start   <= 1'b0;
            line_overrun  <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            d_s1          <= idata;
            d_s2          <= d_s1;
            x             <= x_n;
            y             <= y_n;
            locked        <= locked_n;
            wr_en         <= wr_en_n;
            wr_addr       <= wr_n.addr;
            wr_data       <= wr_n.data;
            frame_start   <= vs_rise;
            line_overrun  <= line_overrun_n;
            frame_overrun <= frame_overrun_n;
        end
    end

endmodule

// File: tb/tb_gb_lcd_capture.sv
// Directed bench for gb_lcd_capture: line table plus hand-written corner sequences.
module tb_gb_lcd_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  idata;
    logic        iclk;
    logic        ihsync;
    logic        ivsync;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic [1:0]  wr_data;
    logic        frame_start;
    logic        locked;
    logic        line_overrun;
    logic        frame_overrun;

    int checks   = 0;
    int failures = 0;
    int fs_cnt   = 0;
    int wa[$];
    logic [1:0] wdat[$];

    always #5 clk = ~clk;

    gb_lcd_capture #(.FILTER_LEN(3), .INVERT_DATA(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .idata(idata), .iclk(iclk),
        .ihsync(ihsync), .ivsync(ivsync), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .frame_start(frame_start), .locked(locked),
        .line_overrun(line_overrun), .frame_overrun(frame_overrun)
    );

    // Record every write and frame_start pulse, sampled away from the active edge.
    always @(negedge clk) begin
        if (wr_en) begin
            wa.push_back(int'(wr_addr));
            wdat.push_back(wr_data);
        end
        if (frame_start) fs_cnt++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pix(input logic [1:0] d);
        @(posedge clk); #1;
        idata = d;
        iclk  = 1'b0;
        repeat (3) @(posedge clk);
        #1 iclk = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic do_hsync();
        @(posedge clk); #1 ihsync = 1'b1;
        repeat (4) @(posedge clk);
        #1 ihsync = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic do_vsync();
        @(posedge clk); #1 ivsync = 1'b1;
        repeat (4) @(posedge clk);
        #1 ivsync = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic pix_vsync(input logic [1:0] d);
        @(posedge clk); #1;
        idata  = d;
        iclk   = 1'b0;
        ivsync = 1'b1;
        repeat (3) @(posedge clk);
        #1 iclk = 1'b1;
        repeat (3) @(posedge clk);
        #1 ivsync = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic run_line(input int n, input logic [1:0] d, input bit hs);
        for (int i = 0; i < n; i++) pix(d);
        if (hs) do_hsync();
    endtask

    typedef struct {
        int         npix;
        logic [1:0] d;
        bit         hs;
        int         exp_n;
        int         exp_first;
        logic [1:0] exp_d;
        logic       exp_lovr;
    } line_vec_t;

    line_vec_t tbl[5];

    initial begin
        int base;
        int bad;

        tbl[0] = '{160, 2'b01, 1'b1, 160,   0, 2'b10, 1'b0};
        tbl[1] = '{161, 2'b11, 1'b1, 160, 160, 2'b00, 1'b1};
        tbl[2] = '{  3, 2'b10, 1'b1,   3, 320, 2'b01, 1'b1};
        tbl[3] = '{  0, 2'b00, 1'b1,   0,   0, 2'b00, 1'b1};
        tbl[4] = '{  2, 2'b00, 1'b1,   2, 480, 2'b11, 1'b1};

        rst_n = 1'b0; iclk = 1'b1; ihsync = 1'b0; ivsync = 1'b0; idata = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        chk("rst_frame_start", int'(frame_start), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_overruns", int'({line_overrun, frame_overrun}), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (8) @(posedge clk);

        // Pixels and line latch before any vsync are ignored.
        base = wa.size();
        run_line(2, 2'b01, 1'b1);
        chk("prelock_writes", wa.size() - base, 0);
        chk("prelock_locked", int'(locked), 0);

        do_vsync();
        chk("lock_after_vsync", int'(locked), 1);
        chk("frame_start_count1", fs_cnt, 1);

        for (int r = 0; r < 5; r++) begin
            base = wa.size();
            run_line(tbl[r].npix, tbl[r].d, tbl[r].hs);
            chk($sformatf("row%0d_count", r), wa.size() - base, tbl[r].exp_n);
            bad = 0;
            for (int i = 0; i < tbl[r].exp_n && base + i < wa.size(); i++) begin
                if (wa[base+i] != tbl[r].exp_first + i || wdat[base+i] != tbl[r].exp_d) bad++;
            end
            chk($sformatf("row%0d_addr_data_errs", r), bad, 0);
            chk($sformatf("row%0d_line_overrun", r), int'(line_overrun), int'(tbl[r].exp_lovr));
        end
        chk("frame_start_once", fs_cnt, 1);

        // Full frame: 143 one-pixel lines, then a full last line.
        do_vsync();
        chk("frame_start_count2", fs_cnt, 2);
        bad = 0;
        for (int yy = 0; yy < 143; yy++) begin
            base = wa.size();
            pix(2'b11);
            do_hsync();
            if (wa.size() != base + 1 || wa[base] != yy * 160) bad++;
        end
        chk("frame_line_start_errs", bad, 0);
        run_line(160, 2'b00, 1'b1);
        chk("frame_last_addr", wa[wa.size()-1], 23039);
        chk("frame_ovr_before", int'(frame_overrun), 0);
        base = wa.size();
        run_line(2, 2'b01, 1'b0);
        chk("line145_writes", wa.size() - base, 0);
        chk("frame_ovr_after", int'(frame_overrun), 1);

        // Pixel coincident with vsync rise goes to address 0, next to 1.
        base = wa.size();
        pix_vsync(2'b10);
        pix(2'b01);
        chk("coinc_writes", wa.size() - base, 2);
        if (wa.size() - base == 2) begin
            chk("coinc_addr0", wa[base], 0);
            chk("coinc_data0", int'(wdat[base]), 1);
            chk("coinc_addr1", wa[base+1], 1);
        end
        chk("frame_start_count3", fs_cnt, 3);

        // Latency: wr_en on the 4th edge after the first synchronizer sample of 0.
        @(posedge clk); #1 idata = 2'b00; iclk = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("lat_edge%0d_wr_en", k), int'(wr_en), (k == 4) ? 1 : 0);
        end
        chk("lat_addr", int'(wr_addr), 2);
        #1 iclk = 1'b1;
        repeat (6) @(posedge clk);

        // Two-cycle low glitch is filtered out; a three-cycle low is one pixel.
        base = wa.size();
        @(posedge clk); #1 iclk = 1'b0;
        repeat (2) @(posedge clk);
        #1 iclk = 1'b1;
        repeat (10) @(posedge clk);
        chk("glitch_writes", wa.size() - base, 0);
        pix(2'b11);
        chk("min_pulse_writes", wa.size() - base, 1);
        chk("min_pulse_addr", int'(wr_addr), 3);

        // Reset mid-line clears flags and blocks writes until the next vsync.
        @(posedge clk); #1 iclk = 1'b0; idata = 2'b01;
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_wr_en", int'(wr_en), 0);
        chk("midrst_locked", int'(locked), 0);
        chk("midrst_overruns", int'({line_overrun, frame_overrun}), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 iclk = 1'b1;
        repeat (6) @(posedge clk);
        base = wa.size();
        run_line(3, 2'b01, 1'b1);
        chk("postrst_writes", wa.size() - base, 0);
        chk("postrst_locked", int'(locked), 0);
        do_vsync();
        pix(2'b00);
        chk("postrst_vsync_writes", wa.size() - base, 1);
        chk("postrst_addr", wa[wa.size()-1], 0);
        chk("postrst_data", int'(wdat[wdat.size()-1]), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gb_lcd_capture.md
GB_LCD_CAPTURE -- requirements
Module: gb_lcd_capture

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 3: consecutive agreeing synchronized samples needed to change a filtered level (range 2..8).
REQ-002 SHALL have parameter INVERT_DATA, default 1: 1 means wr_data is the bitwise inverse of idata.
REQ-003 SHALL have port clk, input, 1: single clock for all logic, the pixel-domain clock from the PLL.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port idata, input, 2: raw Game Boy LCD pixel data, asynchronous.
REQ-006 SHALL have port iclk, input, 1: raw LCD pixel clock, asynchronous.
REQ-007 SHALL have port ihsync, input, 1: raw LCD line latch, asynchronous.
REQ-008 SHALL have port ivsync, input, 1: raw LCD frame sync, asynchronous.
REQ-009 SHALL have port wr_en, output, 1: one-cycle framebuffer write strobe.
REQ-010 SHALL have port wr_addr, output, 15: framebuffer address, y*160+x.
REQ-011 SHALL have port wr_data, output, 2: pixel value to write.
REQ-012 SHALL have port frame_start, output, 1: one-cycle pulse on accepted vsync rise.
REQ-013 SHALL have port locked, output, 1: high once the first vsync rise after reset has been seen.
REQ-014 SHALL have port line_overrun, output, 1: sticky flag, a pixel arrived with x==160.
REQ-015 SHALL have port frame_overrun, output, 1: sticky flag, a pixel arrived with y==144.

Function
REQ-016 SHALL pass iclk, ihsync, ivsync and idata through two flops each before any use.
REQ-017 Each filtered level (iclk, ihsync, ivsync) SHALL change only when the current synchronized sample and the previous FILTER_LEN-1 samples all equal the new value; a shorter pulse is ignored.
REQ-018 A pixel event SHALL occur on the cycle the filtered iclk changes 1->0.
REQ-019 wr_en SHALL be high for exactly one cycle, starting FILTER_LEN+1 clk edges after the edge at which the first iclk synchronizer flop first samples 0, given stable inputs.
REQ-020 wr_data SHALL be the synchronized idata at the pixel-event edge, inverted when INVERT_DATA=1.
REQ-021 wr_addr SHALL be registered together with wr_data and wr_en, and SHALL hold its value when wr_en is low.
REQ-022 On a pixel event with locked=1, x<160 and y<144, the block SHALL write to address y*160+x and then set x to x+1.
REQ-023 On a pixel event with x==160, the block SHALL suppress the write, leave x unchanged and set line_overrun.
REQ-024 On a pixel event with y==144, the block SHALL suppress the write and set frame_overrun.
REQ-025 A filtered ihsync rise SHALL set x to 0; it SHALL increment y (saturating at 144) only when x!=0, so a line latch with no pixels has no effect.
REQ-026 A filtered ivsync rise SHALL set x to 0 and y to 0, set locked to 1 and pulse frame_start for one cycle.
REQ-027 Simultaneous pixel event and vsync rise: the pixel SHALL be written at address 0, and x SHALL become 1.
REQ-028 Simultaneous pixel event and hsync rise: the pixel SHALL be written on the current line, then the line SHALL advance per REQ-025.
REQ-029 While locked=0, all writes SHALL be suppressed and the counters SHALL NOT advance.
REQ-030 The maximum address written SHALL be 23039; the address arithmetic SHALL be unsigned and 15 bits wide.

Reset
REQ-031 When rst_n=0, all synchronizer flops, sample histories, filtered levels, x, y and locked SHALL be 0.
REQ-032 When rst_n=0, wr_en, wr_addr, wr_data, frame_start, line_overrun and frame_overrun SHALL be 0.
REQ-033 Reset mid-frame: after rst_n is released, no write SHALL occur before the next filtered ivsync rise.
REQ-034 The overrun flags SHALL clear only on reset.

Structure
REQ-035 Package gbvga_pkg SHALL hold GB_H_PIX=160, GB_V_LINES=144, FB_ADDR_W=15 and FB_DATA_W=2; this block and the VGA output stage SHALL share it.
REQ-036 Sub-module gb_sig_filter SHALL implement the two-flop synchronizer, the FILTER_LEN history and the filtered level with rise/fall pulses; the block SHALL instance it three times (iclk, ihsync, ivsync).

Verification
REQ-037 Reset release, vsync, then 160 clean iclk pulses with idata=2'b01 -> 160 writes, addresses 0..159, wr_data=2'b10, locked=1, one frame_start.
REQ-038 iclk low glitch of 2 cycles (FILTER_LEN=3) -> no wr_en; a 3-cycle low -> exactly one wr_en, 4 edges after the first sync sample.
REQ-039 Full frame of 144 lines x 160 pixels, each line followed by hsync -> last address 23039; a 145th line's pixels -> no writes, frame_overrun=1.
REQ-040 161 pixels on one line -> the 161st is dropped, line_overrun=1; the next line starts at 160*(y+1).
REQ-041 Pixel event coincident with vsync rise mid-frame -> write at address 0, and the next pixel goes to address 1.
REQ-042 rst_n pulsed low mid-line, then pixels without vsync -> wr_en stays 0 until vsync, after which writes restart at address 0.
